// File: rtl/mux_sel_seq.sv
// Select sequencer for an 8:1 mux. It latches a byte, then steps the mux select
// through all eight inputs, one step per accepted ready handshake.
module mux_sel_seq #(
   parameter bit          MSB_FIRST = 1'b0,
   parameter int unsigned DWELL     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] din,
   input  logic       ready,
   output logic [7:0] I,
   output logic [2:0] s,
   output logic       busy,
   output logic       bit_valid,
   output logic       last,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   localparam logic [3:0] DWELL_MAX = 4'(DWELL - 1);
   localparam logic [2:0] S_START   = MSB_FIRST ? 3'd7 : 3'd0;

   state_t     r_state, w_state;
   logic [7:0] r_i, w_i;
   logic [2:0] r_s, w_s;
   logic [2:0] r_step, w_step;
   logic [3:0] r_dwell, w_dwell;
   logic       r_busy, w_busy;
   logic       r_bit_valid, w_bit_valid;
   logic       r_last, w_last;
   logic       r_done, w_done;
   logic       w_accept;

   // NOTE: every signal gets a default before the case, so no path leaves one
   // unassigned and no latch is inferred; blocking '=' is correct in always_comb.
   always_comb begin
      w_state  = r_state;
      w_i      = r_i;
      w_s      = r_s;
      w_step   = r_step;
      w_dwell  = r_dwell;
      w_accept = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_state = ST_SHIFT;
               w_i     = din;
               w_s     = S_START;
               w_step  = 3'd0;
               w_dwell = 4'd0;
            end
         end
         ST_SHIFT: begin
            w_accept = ready && (r_dwell == DWELL_MAX);
            if (r_dwell != DWELL_MAX) w_dwell = r_dwell + 4'd1;
            if (w_accept) begin
               // The final step leaves s on its end value instead of wrapping it.
               if (r_step == 3'd7) begin
                  w_state = ST_DONE;
               end else begin
                  w_s     = MSB_FIRST ? (r_s - 3'd1) : (r_s + 3'd1);
                  w_step  = r_step + 3'd1;
                  w_dwell = 4'd0;
               end
            end
         end
         ST_DONE: w_state = ST_IDLE;
         default: w_state = ST_IDLE;
      endcase

      // Output flops are loaded from the next state, so they line up with r_state.
      w_busy      = (w_state == ST_SHIFT) || (w_state == ST_DONE);
      w_bit_valid = (w_state == ST_SHIFT);
      w_last      = (w_state == ST_SHIFT) && (w_step == 3'd7);
      w_done      = (w_state == ST_DONE);
   end

   // NOTE: sequential state uses non-blocking '<=' so that all flops update
   // together on the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_i         <= 8'd0;
         r_s         <= 3'd0;
         r_step      <= 3'd0;
         r_dwell     <= 4'd0;
         r_busy      <= 1'b0;
         r_bit_valid <= 1'b0;
         r_last      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_i         <= w_i;
         r_s         <= w_s;
         r_step      <= w_step;
         r_dwell     <= w_dwell;
         r_busy      <= w_busy;
         r_bit_valid <= w_bit_valid;
         r_last      <= w_last;
         r_done      <= w_done;
      end
   end

   assign I         = r_i;
   assign s         = r_s;
   assign busy      = r_busy;
   assign bit_valid = r_bit_valid;
   assign last      = r_last;
   assign done      = r_done;

endmodule

// File: tb/tb_mux_sel_seq.sv
// Directed testbench for mux_sel_seq. It uses one default instance and one
// instance with MSB_FIRST=1 and DWELL=4.
module tb_mux_sel_seq;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;

   logic       load0 = 1'b0, ready0 = 1'b0;
   logic [7:0] din0  = 8'd0;
   logic [7:0] i0;
   logic [2:0] s0;
   logic       busy0, bv0, last0, done0;

   logic       load1 = 1'b0, ready1 = 1'b0;
   logic [7:0] din1  = 8'd0;
   logic [7:0] i1;
   logic [2:0] s1;
   logic       busy1, bv1, last1, done1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_sel_seq dut0 (
      .clk(clk), .rst_n(rst_n), .load(load0), .din(din0), .ready(ready0),
      .I(i0), .s(s0), .busy(busy0), .bit_valid(bv0), .last(last0), .done(done0)
   );

   mux_sel_seq #(.MSB_FIRST(1'b1), .DWELL(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .load(load1), .din(din1), .ready(ready1),
      .I(i1), .s(s1), .busy(busy1), .bit_valid(bv1), .last(last1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] a_s, input logic [7:0] a_i,
                          input logic a_b, input logic a_v, input logic a_l, input logic a_d,
                          input int e_s, input int e_i, input bit e_b, input bit e_v,
                          input bit e_l, input bit e_d);
      check({tag, " s"},         32'(a_s), 32'(e_s));
      check({tag, " I"},         32'(a_i), 32'(e_i));
      check({tag, " busy"},      32'(a_b), 32'(e_b));
      check({tag, " bit_valid"}, 32'(a_v), 32'(e_v));
      check({tag, " last"},      32'(a_l), 32'(e_l));
      check({tag, " done"},      32'(a_d), 32'(e_d));
   endtask

   task automatic chk0(input string tag, input int e_s, input int e_i, input bit e_b,
                       input bit e_v, input bit e_l, input bit e_d);
      chk_all(tag, s0, i0, busy0, bv0, last0, done0, e_s, e_i, e_b, e_v, e_l, e_d);
   endtask

   task automatic chk1(input string tag, input int e_s, input int e_i, input bit e_b,
                       input bit e_v, input bit e_l, input bit e_d);
      chk_all(tag, s1, i1, busy1, bv1, last1, done1, e_s, e_i, e_b, e_v, e_l, e_d);
   endtask

   task automatic nclk();
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      #1;
      chk0("rst0", 0, 0, 0, 0, 0, 0);
      chk1("rst1", 0, 0, 0, 0, 0, 0);
      nclk();
      nclk();
      rst_n = 1'b1;

      // A: DWELL=1, ready high, s runs 0..7, done appears in the 9th cycle
      load0 = 1'b1; din0 = 8'hAA; ready0 = 1'b1;
      nclk();
      load0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk0($sformatf("A%0d", k), k, 'hAA, 1, 1, k == 7, 0);
         nclk();
      end
      chk0("A_done", 7, 'hAA, 1, 0, 0, 1);
      nclk();
      chk0("A_idle", 7, 'hAA, 0, 0, 0, 0);

      // B: ready alternates, so each s value is held for two cycles
      load0 = 1'b1;
      nclk();
      load0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         ready0 = 1'b0;
         chk0($sformatf("B%0da", k), k, 'hAA, 1, 1, k == 7, 0);
         nclk();
         ready0 = 1'b1;
         chk0($sformatf("B%0db", k), k, 'hAA, 1, 1, k == 7, 0);
         nclk();
      end
      chk0("B_done", 7, 'hAA, 1, 0, 0, 1);
      nclk();
      chk0("B_idle", 7, 'hAA, 0, 0, 0, 0);

      // C: a load and a new din during the frame are both ignored
      load0 = 1'b1; din0 = 8'hAA;
      nclk();
      load0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin din0 = 8'h55; load0 = 1'b1; end
         if (k == 4) load0 = 1'b0;
         chk0($sformatf("C%0d", k), k, 'hAA, 1, 1, k == 7, 0);
         nclk();
      end
      chk0("C_done", 7, 'hAA, 1, 0, 0, 1);
      nclk();
      chk0("C_idle", 7, 'hAA, 0, 0, 0, 0);

      // D: reset asserted at s=5 aborts the frame immediately
      load0 = 1'b1; din0 = 8'hC3;
      nclk();
      load0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk0($sformatf("D%0d", k), k, 'hC3, 1, 1, 0, 0);
         nclk();
      end
      chk0("D5", 5, 'hC3, 1, 1, 0, 0);
      rst_n = 1'b0;
      #1;
      chk0("D_async_rst", 0, 0, 0, 0, 0, 0);
      nclk();
      chk0("D_rst_hold", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1; load0 = 1'b1; din0 = 8'h0F;
      nclk();
      load0 = 1'b0;
      chk0("D_reload0", 0, 'h0F, 1, 1, 0, 0);
      for (int k = 1; k < 8; k++) begin
         nclk();
         chk0($sformatf("D_re%0d", k), k, 'h0F, 1, 1, k == 7, 0);
      end
      nclk();
      chk0("D_done", 7, 'h0F, 1, 0, 0, 1);
      nclk();
      chk0("D_idle", 7, 'h0F, 0, 0, 0, 0);

      // E: load held high gives back-to-back frames (8 steps, DONE, IDLE)
      load0 = 1'b1; din0 = 8'h5A;
      nclk();
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 8; k++) begin
            chk0($sformatf("E%0d_%0d", f, k), k, 'h5A, 1, 1, k == 7, 0);
            nclk();
         end
         chk0($sformatf("E%0d_done", f), 7, 'h5A, 1, 0, 0, 1);
         nclk();
         if (f == 2) load0 = 1'b0;
         chk0($sformatf("E%0d_idle", f), 7, 'h5A, 0, 0, 0, 0);
         nclk();
      end
      chk0("E_stay_idle", 7, 'h5A, 0, 0, 0, 0);

      // F: MSB_FIRST=1 and DWELL=4, so s runs 7..0 with 4 cycles per value and done in cycle 33
      load1 = 1'b1; din1 = 8'h3C; ready1 = 1'b1;
      nclk();
      load1 = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         for (int d = 0; d < 4; d++) begin
            chk1($sformatf("F%0d_%0d", k, d), k, 'h3C, 1, 1, k == 0, 0);
            nclk();
         end
      end
      chk1("F_done", 0, 'h3C, 1, 0, 0, 1);
      nclk();
      chk1("F_idle", 0, 'h3C, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
